// File: rtl/scpu_fetch_pkg.sv
// Shared constants and helpers for the SCPU instruction-fetch front end.
package scpu_fetch_pkg;

    localparam logic [1:0] REDIR_JMP  = 2'b00;
    localparam logic [1:0] REDIR_CALL = 2'b01;
    localparam logic [1:0] REDIR_RET  = 2'b10;

    // Pointer width for an n-entry ring; never narrower than one bit.
    function automatic int ptr_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/scpu_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty only raises the sticky underflow flag.
module scpu_ras
    import scpu_fetch_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              ovf,
    output logic              unf
);

    localparam int PW = ptr_w(RAS_DEPTH);
    localparam int OW = $clog2(RAS_DEPTH + 1);
    localparam logic [OW-1:0] FULL_C = OW'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_r [2**PW];
    logic [PW-1:0]     sp_r;
    logic [PW-1:0]     sp_nxt_s;
    logic [OW-1:0]     occ_r;
    logic              ovf_r;
    logic              unf_r;

    assign sp_nxt_s = sp_r + PW'(1);

    // Entry storage; the slot above the top is always the next write target.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_r[sp_nxt_s] <= din;
        end
    end

    // Stack pointer, saturating occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_r  <= {PW{1'b0}};
            occ_r <= {OW{1'b0}};
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else if (push) begin
            sp_r <= sp_nxt_s;
            if (occ_r == FULL_C) begin
                ovf_r <= 1'b1;
            end else begin
                occ_r <= occ_r + OW'(1);
            end
        end else if (pop) begin
            if (occ_r != {OW{1'b0}}) begin
                sp_r  <= sp_r - PW'(1);
                occ_r <= occ_r - OW'(1);
            end else begin
                unf_r <= 1'b1;
            end
        end
    end

    assign top   = mem_r[sp_r];
    assign empty = (occ_r == {OW{1'b0}});
    assign ovf   = ovf_r;
    assign unf   = unf_r;

endmodule

// File: rtl/scpu_fetch_unit.sv
// SCPU fetch front end: PC, prefetch FIFO with valid/ready decode handshake,
// and redirect handling backed by the return-address stack.
module scpu_fetch_unit
    import scpu_fetch_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                INS_W     = 16,
    parameter int                DEPTH     = 4,
    parameter int                RAS_DEPTH = 4,
    parameter int                PC_STEP   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic [INS_W-1:0]  imem_rdata,
    output logic              ins_valid,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              ins_ready,
    input  logic              redir_valid,
    input  logic [1:0]        redir_kind,
    input  logic [ADDR_W-1:0] redir_target,
    input  logic [ADDR_W-1:0] redir_link,
    output logic              ras_empty,
    output logic              ras_ovf,
    output logic              ras_unf
);

    localparam int QPW = ptr_w(DEPTH);
    localparam logic [QPW:0]      DEPTH_C = (QPW + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

    logic [INS_W-1:0]  ins_mem_r [DEPTH];
    logic [ADDR_W-1:0] pc_mem_r  [DEPTH];
    logic [QPW-1:0]    wr_ptr_r;
    logic [QPW-1:0]    rd_ptr_r;
    logic [QPW:0]      count_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] redir_pc_s;
    logic [ADDR_W-1:0] ras_top_s;
    logic              valid_s;
    logic              pop_s;
    logic              fetch_s;
    logic              ras_push_s;
    logic              ras_pop_s;

    assign valid_s    = (count_r != {(QPW + 1){1'b0}});
    assign pop_s      = valid_s & ins_ready & ~redir_valid;
    // A pop frees a slot this cycle, so a full queue can still accept a fetch.
    assign fetch_s    = ~rst & ~redir_valid & ((count_r < DEPTH_C) | pop_s);
    assign ras_push_s = redir_valid & (redir_kind == REDIR_CALL);
    assign ras_pop_s  = redir_valid & (redir_kind == REDIR_RET);

    scpu_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push_s),
        .pop   (ras_pop_s),
        .din   (redir_link),
        .top   (ras_top_s),
        .empty (ras_empty),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

    // Redirect target selection; reserved kind behaves as a jump.
    always_comb begin
        redir_pc_s = redir_target;
        case (redir_kind)
            REDIR_RET: begin
                if (ras_empty) begin
                    redir_pc_s = redir_target;
                end else begin
                    redir_pc_s = ras_top_s;
                end
            end
            default: redir_pc_s = redir_target;
        endcase
    end

    // Queue payload storage written at the tail on every fetch.
    always_ff @(posedge clk) begin
        if (fetch_s) begin
            ins_mem_r[wr_ptr_r] <= imem_rdata;
            pc_mem_r[wr_ptr_r]  <= pc_r;
        end
    end

    // PC, queue pointers and occupancy; a redirect flushes the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            wr_ptr_r <= {QPW{1'b0}};
            rd_ptr_r <= {QPW{1'b0}};
            count_r  <= {(QPW + 1){1'b0}};
        end else if (redir_valid) begin
            pc_r     <= redir_pc_s;
            wr_ptr_r <= {QPW{1'b0}};
            rd_ptr_r <= {QPW{1'b0}};
            count_r  <= {(QPW + 1){1'b0}};
        end else begin
            if (fetch_s) begin
                wr_ptr_r <= wr_ptr_r + QPW'(1);
                pc_r     <= pc_r + STEP_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + QPW'(1);
            end
            case ({fetch_s, pop_s})
                2'b10:   count_r <= count_r + (QPW + 1)'(1);
                2'b01:   count_r <= count_r - (QPW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign imem_addr = pc_r;
    assign imem_req  = fetch_s;
    assign ins_valid = valid_s;
    assign ins       = valid_s ? ins_mem_r[rd_ptr_r] : {INS_W{1'b0}};
    assign ins_pc    = valid_s ? pc_mem_r[rd_ptr_r]  : {ADDR_W{1'b0}};

endmodule

// File: tb/tb_scpu_fetch_unit.sv
// Bench for scpu_fetch_unit: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
module tb_scpu_fetch_unit;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       ins_ready = 1'b0;
    logic       redir_valid = 1'b0;
    logic [1:0] redir_kind = 2'b00;
    logic [7:0] redir_target = 8'h00;
    logic [7:0] redir_link = 8'h00;

    logic [7:0]  imem_addr, ins_pc;
    logic [15:0] imem_rdata, ins;
    logic        imem_req, ins_valid, ras_empty, ras_ovf, ras_unf;

    logic [7:0]  imem_addr_fc, ins_pc_fc;
    logic [15:0] imem_rdata_fc, ins_fc;
    logic        imem_req_fc, ins_valid_fc, ras_empty_fc, ras_ovf_fc, ras_unf_fc;

    assign imem_rdata    = {imem_addr, 8'hA5};
    assign imem_rdata_fc = {imem_addr_fc, 8'hA5};

    scpu_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc),
        .ins_ready(ins_ready), .redir_valid(redir_valid), .redir_kind(redir_kind),
        .redir_target(redir_target), .redir_link(redir_link),
        .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    scpu_fetch_unit #(.RESET_PC(8'hFC)) dut_fc (
        .clk(clk), .rst(rst), .imem_addr(imem_addr_fc), .imem_req(imem_req_fc),
        .imem_rdata(imem_rdata_fc), .ins_valid(ins_valid_fc), .ins(ins_fc),
        .ins_pc(ins_pc_fc), .ins_ready(1'b1), .redir_valid(1'b0), .redir_kind(2'b00),
        .redir_target(8'h00), .redir_link(8'h00),
        .ras_empty(ras_empty_fc), .ras_ovf(ras_ovf_fc), .ras_unf(ras_unf_fc)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] word;
    } ent_t;

    ent_t       q[$];
    logic [7:0] stk[$];
    logic [7:0] m_pc = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;
    int         nrst = 0;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model, advance the model.
    task automatic step(input bit r, input bit rdy, input bit rv, input logic [1:0] k,
                        input logic [7:0] tgt, input logic [7:0] lnk);
        bit   hv;
        bit   req;
        ent_t e;
        rst = r; ins_ready = rdy; redir_valid = rv;
        redir_kind = k; redir_target = tgt; redir_link = lnk;
        #1;
        hv  = (q.size() > 0);
        req = !r && !rv && ((q.size() < 4) || (hv && rdy));
        chk("ins_valid", 32'(ins_valid), 32'(hv));
        chk("ins", 32'(ins), hv ? 32'(q[0].word) : 32'h0);
        chk("ins_pc", 32'(ins_pc), hv ? 32'(q[0].pc) : 32'h0);
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("imem_req", 32'(imem_req), 32'(req));
        chk("ras_empty", 32'(ras_empty), 32'(stk.size() == 0));
        chk("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
        chk("ras_unf", 32'(ras_unf), 32'(m_unf));
        if (nrst >= 1 && nrst <= 4) begin
            chk("fc_ins_pc", 32'(ins_pc_fc), 32'(8'(8'hFC + 8'(2 * (nrst - 1)))));
        end
        if (r) begin
            q.delete(); stk.delete();
            m_pc = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (rv) begin
            q.delete();
            if (k == 2'b01) begin
                stk.push_back(lnk);
                if (stk.size() > 4) begin
                    void'(stk.pop_front());
                    m_ovf = 1'b1;
                end
                m_pc = tgt;
            end else if (k == 2'b10) begin
                if (stk.size() > 0) begin
                    m_pc = stk.pop_back();
                end else begin
                    m_pc = tgt;
                    m_unf = 1'b1;
                end
            end else begin
                m_pc = tgt;
            end
        end else begin
            if (hv && rdy) void'(q.pop_front());
            if (req) begin
                e.pc = m_pc; e.word = {m_pc, 8'hA5};
                q.push_back(e);
                m_pc = m_pc + 8'd2;
            end
        end
        @(posedge clk);
        nrst = r ? 0 : nrst + 1;
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, 2'b00, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Streaming from reset
        do_reset();
        idle(1'b1, 1);
        chk("first_valid", 32'(ins_valid), 32'h1);
        chk("first_pc", 32'(ins_pc), 32'h00);
        chk("first_ins", 32'(ins), 32'h00A5);
        idle(1'b1, 5);
        chk("stream_pc", 32'(ins_pc), 32'h0A);

        // Back-pressure fills the queue then stalls fetch
        do_reset();
        idle(1'b0, 6);
        chk("full_addr", 32'(imem_addr), 32'h08);
        chk("full_req", 32'(imem_req), 32'h0);
        idle(1'b1, 1);
        chk("drain_pc", 32'(ins_pc), 32'h02);
        idle(1'b1, 4);

        // Jump flushes queued entries
        do_reset();
        idle(1'b0, 3);
        step(1'b0, 1'b1, 1'b1, 2'b00, 8'h40, 8'h00);
        chk("jmp_valid", 32'(ins_valid), 32'h0);
        chk("jmp_addr", 32'(imem_addr), 32'h40);
        idle(1'b1, 1);
        chk("jmp_head", 32'(ins_pc), 32'h40);

        // Call then return
        step(1'b0, 1'b1, 1'b1, 2'b01, 8'h80, 8'h12);
        idle(1'b1, 3);
        step(1'b0, 1'b1, 1'b1, 2'b10, 8'h55, 8'h00);
        chk("ret_addr", 32'(imem_addr), 32'h12);
        chk("ret_empty", 32'(ras_empty), 32'h1);

        // Overflow, four returns, underflow, then reset clears flags
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 2'b01, 8'(8'h80 + 8'(i)), 8'(8'h10 + 8'(2 * i)));
        chk("ovf_set", 32'(ras_ovf), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 2'b10, 8'h00, 8'h00);
            chk("ret_seq", 32'(imem_addr), 32'(8'(8'h18 - 8'(2 * i))));
        end
        step(1'b0, 1'b1, 1'b1, 2'b10, 8'h33, 8'h00);
        chk("unf_addr", 32'(imem_addr), 32'h33);
        chk("unf_set", 32'(ras_unf), 32'h1);
        idle(1'b1, 3);
        step(1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
        chk("rst_ovf", 32'(ras_ovf), 32'h0);
        chk("rst_unf", 32'(ras_unf), 32'h0);
        chk("rst_valid", 32'(ins_valid), 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scpu_fetch_unit.md
# scpu_fetch_unit

Parametrised instruction-fetch front end for the pipelined SCPU family, replacing the fixed 8-bit PC, +2 adder, single link register and PC mux. It owns the PC and a DEPTH-entry prefetch queue that decouples instruction memory from decode via a valid/ready handshake. A RAS_DEPTH-entry return-address stack replaces the single link register. Branch resolution drives one redirect port that flushes the queue and retargets fetch.

## Interface
Parameters:
- ADDR_W, 8: PC / instruction address width.
- INS_W, 16: instruction width.
- DEPTH, 4: prefetch queue entries; power of two, ≥2.
- RAS_DEPTH, 4: return-address stack entries; power of two, ≥1.
- PC_STEP, 2: sequential PC increment.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  fetch address; equals the PC.
- imem_req  out  1  fetch issued this cycle.
- imem_rdata  in  INS_W  instruction at imem_addr; combinational, valid in the same cycle.
- ins_valid  out  1  queue head valid.
- ins  out  INS_W  head instruction; 0 when ins_valid=0.
- ins_pc  out  ADDR_W  head address; 0 when ins_valid=0.
- ins_ready  in  1  decode accepts the head.
- redir_valid  in  1  redirect request.
- redir_kind  in  2  00 jump, 01 call, 10 return, 11 reserved (treated as jump).
- redir_target  in  ADDR_W  target for jump and call; fallback target for return when the stack is empty.
- redir_link  in  ADDR_W  return address pushed on a call.
- ras_empty  out  1  return stack empty.
- ras_ovf  out  1  sticky: a call overwrote an entry.
- ras_unf  out  1  sticky: a return was issued with the stack empty.

## Operation
- pop = ins_valid & ins_ready & ~redir_valid.
- imem_req = ~rst & ~redir_valid & (count < DEPTH | pop).
- On a fetch, {imem_rdata, PC} is pushed at the tail and PC ← PC + PC_STEP, modulo 2^ADDR_W. Wrap is silent.
- Push and pop in the same cycle leaves count unchanged. This is legal when full.
- Order is strict FIFO. No entry is dropped except by a flush.
- Redirect (redir_valid=1) does all of the following:
  - Flush the queue (count ← 0). Any concurrent ins_ready is ignored.
  - jump: PC ← redir_target.
  - call: PC ← redir_target; push redir_link onto the return stack.
  - return, stack non-empty: PC ← top of stack; pop the stack.
  - return, stack empty: PC ← redir_target; set ras_unf.
- Return stack is circular. A call when full overwrites the oldest entry, sets ras_ovf, and leaves ras_empty=0. Occupancy saturates at RAS_DEPTH.
- ras_ovf and ras_unf clear only on rst.
- Reset values: PC=RESET_PC, queue empty, ins_valid=0, ins=0, ins_pc=0, imem_req=0, imem_addr=RESET_PC, stack empty (ras_empty=1), ras_ovf=0, ras_unf=0.
- Reset asserted mid-operation discards queue and stack contents on that edge.

## Timing
- Fetch at cycle N → entry visible at the head in cycle N+1 at the earliest. Queue outputs are registered.
- With ins_ready held at 1, throughput is one instruction per cycle with no bubbles after the first.
- Redirect at cycle N:
  - ins_valid=0 in N+1.
  - imem_addr = new PC in N+1, with imem_req=1.
  - First target instruction at the head in N+2.
  - Redirect penalty: 2 cycles.
- Back-to-back redirects: each one overrides the previous; only the last target is fetched.
- First fetch after rst falls occurs in the first cycle with rst=0.

## Structure
- Package scpu_fetch_pkg holds:
  - redir_kind constants: REDIR_JMP, REDIR_CALL, REDIR_RET.
  - a clog2-based pointer-width helper.
- Sub-module scpu_ras implements the return-address stack:
  - inputs: push, pop, din.
  - outputs: top, empty, ovf, unf.
  - parameters: RAS_DEPTH, ADDR_W.
- The queue is inline: read/write pointers of width clog2(DEPTH) plus a count of width clog2(DEPTH)+1.

## Test plan
Default parameters unless stated; the memory model returns {addr, 8'hA5}.
- Reset for 2 cycles, then ins_ready=1 → ins_pc = 00, 02, 04, … on consecutive cycles; first ins_valid one cycle after the first fetch; ins=16'h00A5.
- ins_ready=0 → exactly 4 fetches, then imem_req=0 with PC held at 08. Raise ready → heads 00, 02, 04, 06, 08 with no gap cycles.
- RESET_PC=8'hFC → ins_pc sequence FC, FE, 00, 02.
- With 3 entries queued, jump to 40 → ins_valid=0 next cycle and imem_addr=40; the following cycle ins_pc=40; old entries never appear.
- Call to 80 with link 12, stream, then return → imem_addr=12 one cycle later and ras_empty=1.
- Five calls with links 10, 12, 14, 16, 18 → ras_ovf=1. Four returns target 18, 16, 14, 12. A fifth return with redir_target=33 → PC=33 and ras_unf=1. rst mid-stream clears both flags and ins_valid on the next edge.
